// File: rtl/snr_ctrl_pkg.sv
// Shared types and helpers for the SNR measurement controller and its tick source.
package snr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE   = 2'd0,
    ST_QUIET    = 2'd1,
    ST_QUIET_OK = 2'd2
  } ctrl_state_t;

  // Number of clk cycles in one millisecond (floor), never less than one.
  function automatic int unsigned ms_to_ticks(input int unsigned clk_hz);
    int unsigned t;
    t = clk_hz / 32'd1000;
    return (t == 32'd0) ? 32'd1 : t;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick generator: free-running prescaler, one-cycle tick on wrap.
module ms_tick_gen
  import snr_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ = 18_432_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned PERIOD = ms_to_ticks(CLK_HZ);
  localparam int unsigned PW     = (PERIOD > 32'd1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] LAST = PW'(PERIOD - 32'd1);

  logic [PW-1:0] count;

  // Prescaler counts 0..PERIOD-1 and restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/snr_measure_ctrl.sv
// SNR measurement sequencer: derives quiet windows from drum events, gates
// noise-floor estimation and holds the last trustworthy SNR with an age flag.
module snr_measure_ctrl
  import snr_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 18_432_000,
  parameter int unsigned HOLDOFF_MS   = 200,
  parameter int unsigned MIN_QUIET_MS = 100,
  parameter int unsigned STALE_MS     = 5000,
  parameter int unsigned SNR_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 beat_pulse,
  input  logic                 snare_pulse,
  input  logic                 hihat_pulse,
  input  logic [SNR_WIDTH-1:0] snr_db,
  input  logic                 snr_valid,
  output logic                 snr_ready,
  output logic                 quiet_period,
  output logic [SNR_WIDTH-1:0] snr_hold,
  output logic                 snr_hold_valid,
  output logic                 snr_stale,
  output logic [1:0]           ctrl_state
);

  localparam int unsigned HOLD_W  = $clog2(HOLDOFF_MS + 32'd1);
  localparam int unsigned QUIET_W = $clog2(MIN_QUIET_MS + 32'd1);
  localparam int unsigned AGE_W   = $clog2(STALE_MS + 32'd1);

  localparam logic [HOLD_W-1:0]  HOLD_LIM  = HOLD_W'(HOLDOFF_MS);
  localparam logic [QUIET_W-1:0] QUIET_LIM = QUIET_W'(MIN_QUIET_MS);
  localparam logic [AGE_W-1:0]   AGE_LIM   = AGE_W'(STALE_MS);

  ctrl_state_t        state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [QUIET_W-1:0] quiet_cnt;
  logic [AGE_W-1:0]   age_cnt;
  logic               noise_ok;
  logic               tick;
  logic               any_event;
  logic               capture;
  logic [HOLD_W-1:0]  hold_next;
  logic [QUIET_W-1:0] quiet_next;
  logic [AGE_W-1:0]   age_next;

  ms_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign any_event = beat_pulse | snare_pulse | hihat_pulse;

  // Only results produced after a validated noise estimate, while music plays, are kept.
  assign capture = snr_valid & snr_ready & (state == ST_ACTIVE) & noise_ok;

  // Saturating next values: counters park at their limit rather than wrapping.
  assign hold_next  = (hold_cnt == HOLD_LIM)   ? hold_cnt  : hold_cnt + 1'b1;
  assign quiet_next = (quiet_cnt == QUIET_LIM) ? quiet_cnt : quiet_cnt + 1'b1;
  assign age_next   = (age_cnt == AGE_LIM)     ? age_cnt   : age_cnt + 1'b1;

  assign ctrl_state = state;

  // Sequencer, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_ACTIVE;
      hold_cnt       <= '0;
      quiet_cnt      <= '0;
      age_cnt        <= '0;
      noise_ok       <= 1'b0;
      quiet_period   <= 1'b0;
      snr_ready      <= 1'b0;
      snr_hold       <= '0;
      snr_hold_valid <= 1'b0;
      snr_stale      <= 1'b1;
    end else begin
      snr_ready <= 1'b1;

      // An event always beats a threshold tick in the same cycle.
      case (state)
        ST_ACTIVE: begin
          if (any_event) begin
            hold_cnt <= '0;
          end else if (tick) begin
            hold_cnt <= hold_next;
            if (hold_next == HOLD_LIM) begin
              state        <= ST_QUIET;
              quiet_cnt    <= '0;
              quiet_period <= 1'b1;
            end
          end
        end
        ST_QUIET: begin
          if (any_event) begin
            // Estimate in progress is discarded; a previous good one stays valid.
            state        <= ST_ACTIVE;
            hold_cnt     <= '0;
            quiet_period <= 1'b0;
          end else if (tick) begin
            quiet_cnt <= quiet_next;
            if (quiet_next == QUIET_LIM) begin
              state    <= ST_QUIET_OK;
              noise_ok <= 1'b1;
            end
          end
        end
        ST_QUIET_OK: begin
          if (any_event) begin
            state        <= ST_ACTIVE;
            hold_cnt     <= '0;
            quiet_period <= 1'b0;
          end else if (tick) begin
            quiet_cnt <= quiet_next;
          end
        end
        default: begin
          state        <= ST_ACTIVE;
          hold_cnt     <= '0;
          quiet_period <= 1'b0;
        end
      endcase

      // Capture refreshes the held value and its age; a tick alone ages it.
      if (capture) begin
        snr_hold       <= snr_db;
        snr_hold_valid <= 1'b1;
        age_cnt        <= '0;
        snr_stale      <= 1'b0;
      end else if (tick) begin
        age_cnt   <= age_next;
        snr_stale <= ~snr_hold_valid | (age_next == AGE_LIM);
      end
    end
  end

endmodule

// File: tb/tb_snr_measure_ctrl.sv
// Self-checking bench for snr_measure_ctrl: directed scenarios plus random
// traffic, compared every cycle against a silence/age based reference model.
module tb_snr_measure_ctrl;

  localparam int H  = 4;   // holdoff ticks
  localparam int M  = 3;   // minimum quiet ticks
  localparam int ST = 20;  // stale ticks
  localparam int TP = 10;  // cycles per tick

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       beat_pulse = 1'b0, snare_pulse = 1'b0, hihat_pulse = 1'b0;
  logic [7:0] snr_db = 8'd0;
  logic       snr_valid = 1'b0;
  logic       snr_ready, quiet_period, snr_hold_valid, snr_stale;
  logic [7:0] snr_hold;
  logic [1:0] ctrl_state;

  int tests = 0;
  int fails = 0;

  // Reference model: ticks of silence since the last event, ticks since capture.
  int         k;
  int         silence;
  int         age;
  bit         nok;
  bit         rdy;
  bit         held;
  logic [7:0] hold_m;

  snr_measure_ctrl #(
    .CLK_HZ(10_000), .HOLDOFF_MS(H), .MIN_QUIET_MS(M),
    .STALE_MS(ST), .SNR_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset),
    .beat_pulse(beat_pulse), .snare_pulse(snare_pulse), .hihat_pulse(hihat_pulse),
    .snr_db(snr_db), .snr_valid(snr_valid), .snr_ready(snr_ready),
    .quiet_period(quiet_period), .snr_hold(snr_hold),
    .snr_hold_valid(snr_hold_valid), .snr_stale(snr_stale),
    .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit ev, input bit v, input logic [7:0] db);
    bit tick;
    bit cap;
    if (rst) begin
      k = 0; silence = 0; age = 0; nok = 0; rdy = 0; held = 0; hold_m = 8'd0;
    end else begin
      tick = ((k % TP) == TP - 1);
      cap  = v && rdy && (silence < H) && nok;
      if (ev) silence = 0;
      else if (tick && silence < H + M) silence++;
      if (silence >= H + M) nok = 1;
      if (cap) begin
        hold_m = db; held = 1; age = 0;
      end else if (tick && age < ST) begin
        age++;
      end
      rdy = 1;
      k++;
    end
  endtask

  function automatic int exp_state();
    return (silence >= H + M) ? 2 : ((silence >= H) ? 1 : 0);
  endfunction

  task automatic compare_all();
    check("quiet_period", quiet_period, (silence >= H) ? 1 : 0);
    check("snr_ready", snr_ready, rdy);
    check("snr_hold", snr_hold, hold_m);
    check("snr_hold_valid", snr_hold_valid, held);
    check("snr_stale", snr_stale, (!held || age >= ST) ? 1 : 0);
    check("ctrl_state", ctrl_state, exp_state());
  endtask

  // One clock cycle: drive inputs, clock, step the model, compare everything.
  task automatic cyc(input bit rst, input bit b, input bit s, input bit h,
                     input bit v, input logic [7:0] db);
    reset = rst; beat_pulse = b; snare_pulse = s; hihat_pulse = h;
    snr_valid = v; snr_db = db;
    @(posedge clk);
    #1;
    model_step(rst, b | s | h, v, db);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic idle_to_phase(input int ph);
    for (int i = 0; i < TP && (k % TP) != ph; i++) idle(1);
    check("phase_reached", k % TP, ph);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_qp"}, quiet_period, 0);
    check({tag, "_ready"}, snr_ready, 0);
    check({tag, "_hold"}, snr_hold, 0);
    check({tag, "_hvalid"}, snr_hold_valid, 0);
    check({tag, "_stale"}, snr_stale, 1);
    check({tag, "_state"}, ctrl_state, 0);
  endtask

  initial begin
    int qp_seen;
    int p;

    // Reset values.
    cyc(1'b1, 0, 0, 0, 0, 8'd0);
    cyc(1'b1, 0, 0, 0, 0, 8'd0);
    check_reset_values("rst");

    // 1: silence -> QUIET after the 4th tick (cycle 39), QUIET_OK after the 7th (69).
    idle(39);
    check("t1_active_before_4th_tick", ctrl_state, 0);
    idle(1);
    check("t1_quiet", ctrl_state, 1);
    check("t1_qp", quiet_period, 1);
    idle(30);
    check("t1_quiet_ok", ctrl_state, 2);
    check("t1_stale", snr_stale, 1);
    check("t1_hvalid", snr_hold_valid, 0);

    // 2: beat every 2 ticks keeps the block ACTIVE.
    cyc(1'b1, 0, 0, 0, 0, 8'd0);
    qp_seen = 0;
    for (int r = 0; r < 6; r++) begin
      cyc(1'b0, 1, 0, 0, 0, 8'd0);
      if (quiet_period) qp_seen++;
      for (int j = 0; j < 19; j++) begin
        idle(1);
        if (quiet_period) qp_seen++;
      end
    end
    check("t2_qp_never", qp_seen, 0);
    check("t2_state", ctrl_state, 0);

    // 3: hihat on the first quiet tick aborts; no noise estimate, result dropped.
    cyc(1'b1, 0, 0, 0, 0, 8'd0);
    idle(40);
    check("t3_quiet", ctrl_state, 1);
    idle(9);
    cyc(1'b0, 0, 0, 1, 0, 8'd0);
    check("t3_back_active", ctrl_state, 0);
    check("t3_qp_low", quiet_period, 0);
    check("t3_ready", snr_ready, 1);
    cyc(1'b0, 0, 0, 0, 1, 8'd30);
    check("t3_dropped_hold", snr_hold, 0);
    check("t3_dropped_hvalid", snr_hold_valid, 0);

    // 4: reach QUIET_OK, beat, then capture 42.
    idle(70);
    check("t4_quiet_ok", ctrl_state, 2);
    cyc(1'b0, 1, 0, 0, 0, 8'd0);
    check("t4_active", ctrl_state, 0);
    cyc(1'b0, 0, 0, 0, 1, 8'd42);
    check("t4_hold", snr_hold, 42);
    check("t4_hvalid", snr_hold_valid, 1);
    check("t4_stale", snr_stale, 0);

    // 5: age out, then capture 17 on a tick cycle.
    idle(200);
    check("t5_stale", snr_stale, 1);
    check("t5_hold_kept", snr_hold, 42);
    idle_to_phase(TP - 2);
    cyc(1'b0, 0, 1, 0, 0, 8'd0);
    cyc(1'b0, 0, 0, 0, 1, 8'd17);
    check("t5_fresh", snr_stale, 0);
    check("t5_hold", snr_hold, 17);

    // 6: event on the 4th holdoff tick wins; reset from QUIET_OK clears everything.
    cyc(1'b1, 0, 0, 0, 0, 8'd0);
    idle(39);
    cyc(1'b0, 1, 0, 0, 0, 8'd0);
    check("t6_event_wins", ctrl_state, 0);
    check("t6_qp", quiet_period, 0);
    idle(70);
    check("t6_quiet_ok", ctrl_state, 2);
    cyc(1'b0, 1, 0, 0, 0, 8'd0);
    cyc(1'b0, 0, 0, 0, 1, 8'd99);
    check("t6_hold99", snr_hold, 99);
    idle(80);
    check("t6_quiet_ok2", ctrl_state, 2);
    cyc(1'b1, 0, 0, 0, 0, 8'd0);
    check_reset_values("t6_rst");

    // Random traffic with varying event density and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ((i % 500) == 0) begin
        case ($urandom_range(2, 0))
          0: p = 40;
          1: p = 250;
          default: p = 1200;
        endcase
      end
      cyc(($urandom_range(1499, 0) == 0),
          ($urandom_range(p - 1, 0) == 0),
          ($urandom_range(p - 1, 0) == 0),
          ($urandom_range(p - 1, 0) == 0),
          ($urandom_range(3, 0) == 0),
          8'($urandom_range(255, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
